// File: rtl/ising_pkg.sv
// rtl/ising_pkg.sv - shared run-controller state encoding and default sizing
package ising_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RESET  = 3'd1,
    RUN    = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } run_state_e;

  localparam int DEF_NUM_SAMPLES = 7;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int RST_CYC_W       = 16;

endpackage

// File: rtl/phase_sync.sv
// rtl/phase_sync.sv - N-wide multi-stage synchronizer for oscillator outputs entering clk
module phase_sync #(
  parameter int N      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  // Stage 0 sits in the low N bits; the oldest sample is at the top.
  logic [STAGES*N-1:0] chain_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[(STAGES-1)*N-1:0], d};
    end
  end

  assign q = chain_q[STAGES*N-1 -: N];

endmodule

// File: rtl/ising_run_ctrl.sv
// rtl/ising_run_ctrl.sv - annealing run sequencer with majority-vote spin readout
// ISING_RUN_CNT_EN adds a saturating run_count output of completed runs.
module ising_run_ctrl
  import ising_pkg::*;
#(
  parameter int N           = 8,
  parameter int CNT_W       = 32,
  parameter int NUM_SAMPLES = DEF_NUM_SAMPLES,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                 clk,
  input  logic                 axi_rstn,
  input  logic                 start,
  input  logic                 abort,
  input  logic [RST_CYC_W-1:0] rst_cycles,
  input  logic [CNT_W-1:0]     run_cycles,
  input  logic [N-1:0]         phase_in,
  output logic                 ising_rstn,
  output logic                 busy,
  output logic                 done,
  output logic [N-1:0]         spins,
  output logic                 spins_valid
`ifdef ISING_RUN_CNT_EN
  ,
  output logic [31:0]          run_count
`endif
);

  localparam int SC_W = $clog2(NUM_SAMPLES + 1);
  localparam logic [SC_W-1:0]  MAJ         = SC_W'(NUM_SAMPLES / 2);
  localparam logic [CNT_W-1:0] SAMPLE_LOAD = CNT_W'(NUM_SAMPLES - 1);

  run_state_e state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [CNT_W-1:0]          run_lat;
  logic [CNT_W-1:0]          run_m1;
  logic [RST_CYC_W-1:0]      rst_m1;
  logic                      cnt_zero;
  logic                      start_acc;
  logic                      enter_sample;
  logic [N-1:0]              sync_phase;
  logic [N-1:0]              mis;
  logic [N-1:0][SC_W-1:0]    scnt_q;
  logic [N-1:0][SC_W-1:0]    scnt_nxt;
  logic [N-1:0]              vote;

  phase_sync #(
    .N      (N),
    .STAGES (SYNC_STAGES)
  ) u_phase_sync (
    .clk  (clk),
    .rstn (axi_rstn),
    .d    (phase_in),
    .q    (sync_phase)
  );

  assign mis = sync_phase ^ {N{sync_phase[0]}};

  // Down-counters hold length-1 so a zero length still gives one cycle.
  assign rst_m1   = (rst_cycles == '0) ? '0 : rst_cycles - 1'b1;
  assign run_m1   = (run_lat == '0) ? '0 : run_lat - 1'b1;
  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RESET;
          cnt_d   = CNT_W'(rst_m1);
        end
      end
      RESET: begin
        if (cnt_zero) begin
          state_d = RUN;
          cnt_d   = run_m1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RUN: begin
        if (cnt_zero) begin
          state_d = SAMPLE;
          cnt_d   = SAMPLE_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SAMPLE: begin
        if (cnt_zero) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  assign start_acc    = (state_q == IDLE) && start && !abort;
  assign enter_sample = (state_q == RUN) && (state_d == SAMPLE);

  // The vote includes the sample taken in the final SAMPLE cycle.
  always_comb begin
    scnt_nxt = '0;
    vote     = '0;
    for (int i = 0; i < N; i++) begin
      scnt_nxt[i] = scnt_q[i] + SC_W'(mis[i]);
      vote[i]     = (scnt_nxt[i] > MAJ);
    end
    vote[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      run_lat     <= '0;
      scnt_q      <= '0;
      ising_rstn  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      spins       <= '0;
      spins_valid <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ising_rstn <= (state_d == RUN) || (state_d == SAMPLE);
      busy       <= (state_d != IDLE);
      done       <= (state_d == DONE);
      if (start_acc) begin
        run_lat     <= run_cycles;
        spins_valid <= 1'b0;
      end
      if (enter_sample) begin
        scnt_q <= '0;
      end else if (state_q == SAMPLE) begin
        scnt_q <= scnt_nxt;
      end
      if (state_d == DONE) begin
        spins       <= vote;
        spins_valid <= 1'b1;
      end
    end
  end

`ifdef ISING_RUN_CNT_EN
  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      run_count <= '0;
    end else if ((state_q == DONE) && (run_count != 32'hFFFF_FFFF)) begin
      run_count <= run_count + 32'd1;
    end
  end
`endif

endmodule
